// File: rtl/cic_decim_ctrl.sv
// -----------------------------------------------------------------------------
// cic_decim_ctrl
//
// Sequencing controller for a decimating CIC filter (integrator + comb
// sections). It holds the integrator/comb registers in clear while the filter
// is started or restarted, gates the integrator advance enable, generates the
// decimation strobe that clocks the comb stages once every R accepted input
// samples, and flags comb output valid once the comb pipeline has settled.
// It also owns the runtime decimation factor R; any legal change of R forces a
// clean restart so the comb pipeline never mixes samples from two rates.
//
// Parameters:
//   RATE_W   width of the decimation factor R
//   DEF_RATE R loaded at reset (legal 2 .. 2^RATE_W-1)
//   N_STG    comb stages = decimated strobes discarded after a restart
//   CLR_CYC  cycles int_clr_o is held while clearing (>= 1)
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous, active-high reset
//   en_i         run enable (level)
//   in_valid_i   input sample strobe at input rate
//   cfg_wr_i     one-cycle write strobe for cfg_rate_i
//   cfg_rate_i   requested decimation factor
//   int_clr_o    clear integrator and comb registers (registered)
//   int_en_o     integrator advance enable (combinational)
//   dec_stb_o    comb enable, one pulse per R accepted samples (registered)
//   out_valid_o  comb output valid (registered)
//   rate_cur_o   decimation factor currently in effect
//   busy_o       high whenever the controller is not in steady-state run
//   cfg_err_o    one-cycle pulse when an illegal cfg_rate_i is rejected
// -----------------------------------------------------------------------------
module cic_decim_ctrl #(
    parameter int unsigned RATE_W   = 8,
    parameter int unsigned DEF_RATE = 4,
    parameter int unsigned N_STG    = 3,
    parameter int unsigned CLR_CYC  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              in_valid_i,
    input  logic              cfg_wr_i,
    input  logic [RATE_W-1:0] cfg_rate_i,
    output logic              int_clr_o,
    output logic              int_en_o,
    output logic              dec_stb_o,
    output logic              out_valid_o,
    output logic [RATE_W-1:0] rate_cur_o,
    output logic              busy_o,
    output logic              cfg_err_o
);

    // Counter widths: clr_cnt spans 0..CLR_CYC-1, settle_cnt spans 0..N_STG.
    localparam int unsigned ClrW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam int unsigned StgW = $clog2(N_STG + 1) > 0 ? $clog2(N_STG + 1) : 1;

    localparam logic [ClrW-1:0]   ClrLast = ClrW'(CLR_CYC - 1);
    localparam logic [StgW-1:0]   StgLast = StgW'(N_STG - 1);
    localparam logic [RATE_W-1:0] RateDef = RATE_W'(DEF_RATE);
    localparam logic [RATE_W-1:0] RateMin = RATE_W'(2);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StSettle,
        StRun
    } state_e;

    state_e            state_q;
    logic [RATE_W-1:0] phase_q;
    logic [StgW-1:0]   settle_cnt_q;
    logic [ClrW-1:0]   clr_cnt_q;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic              int_clr_q;
    logic              dec_stb_q;
    logic              out_valid_q;
    logic              cfg_err_q, cfg_err_d;

    logic cfg_illegal;
    logic rate_change;
    logic dec_active;
    logic period_end;

    // -------------------------------------------------------------------------
    // Configuration decode
    // -------------------------------------------------------------------------
    always_comb begin
        cfg_illegal = cfg_wr_i && (cfg_rate_i < RateMin);
        // Writing the rate already in effect is a no-op: no restart.
        rate_change = cfg_wr_i && !cfg_illegal && (cfg_rate_i != rate_q);
        rate_d      = rate_change ? cfg_rate_i : rate_q;
        cfg_err_d   = cfg_illegal;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rate_q    <= RateDef;
            cfg_err_q <= 1'b0;
        end else begin
            rate_q    <= rate_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Decimation helpers
    // -------------------------------------------------------------------------
    always_comb begin
        dec_active = (state_q == StSettle) || (state_q == StRun);
        // Last accepted sample of the current decimation period.
        period_end = in_valid_i && (phase_q == (rate_q - RATE_W'(1)));
    end

    // -------------------------------------------------------------------------
    // Sequencing FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            phase_q      <= '0;
            settle_cnt_q <= '0;
            clr_cnt_q    <= '0;
            int_clr_q    <= 1'b1;
            dec_stb_q    <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless re-issued below.
            dec_stb_q   <= 1'b0;
            out_valid_q <= 1'b0;

            if ((state_q != StIdle) && !en_i) begin
                // Dropping enable wins over everything, including a restart.
                state_q      <= StIdle;
                phase_q      <= '0;
                settle_cnt_q <= '0;
                clr_cnt_q    <= '0;
                int_clr_q    <= 1'b1;
            end else if ((state_q != StIdle) && rate_change) begin
                // Rate change restarts from a clean clear; a period completing
                // in this same cycle is discarded.
                state_q      <= StClear;
                phase_q      <= '0;
                settle_cnt_q <= '0;
                clr_cnt_q    <= '0;
                int_clr_q    <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        int_clr_q <= 1'b1;
                        // A rate write while idle only updates R this cycle.
                        if (en_i && !rate_change) begin
                            state_q   <= StClear;
                            clr_cnt_q <= '0;
                        end
                    end

                    StClear: begin
                        phase_q      <= '0;
                        settle_cnt_q <= '0;
                        if (clr_cnt_q == ClrLast) begin
                            state_q   <= StSettle;
                            int_clr_q <= 1'b0;
                        end else begin
                            clr_cnt_q <= clr_cnt_q + ClrW'(1);
                        end
                    end

                    StSettle: begin
                        int_clr_q <= 1'b0;
                        if (in_valid_i) begin
                            if (period_end) begin
                                phase_q      <= '0;
                                dec_stb_q    <= 1'b1;
                                settle_cnt_q <= settle_cnt_q + StgW'(1);
                                // The N_STG-th strobe flushes the comb pipeline;
                                // its own output is still invalid.
                                if (settle_cnt_q == StgLast) begin
                                    state_q <= StRun;
                                end
                            end else begin
                                phase_q <= phase_q + RATE_W'(1);
                            end
                        end
                    end

                    StRun: begin
                        int_clr_q <= 1'b0;
                        if (in_valid_i) begin
                            if (period_end) begin
                                phase_q     <= '0;
                                dec_stb_q   <= 1'b1;
                                out_valid_q <= 1'b1;
                            end else begin
                                phase_q <= phase_q + RATE_W'(1);
                            end
                        end
                    end

                    default: begin
                        state_q   <= StIdle;
                        int_clr_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        int_clr_o   = int_clr_q;
        int_en_o    = in_valid_i && dec_active;
        dec_stb_o   = dec_stb_q;
        out_valid_o = out_valid_q;
        rate_cur_o  = rate_q;
        busy_o      = (state_q != StRun);
        cfg_err_o   = cfg_err_q;
    end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cic_decim_ctrl
//
// Self-checking bench for cic_decim_ctrl. A behavioural model tracks the
// filter as "idle / clearing for k cycles / active with a count of accepted
// samples and issued strobes" and predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_cic_decim_ctrl;

    localparam int unsigned RATE_W   = 8;
    localparam int unsigned DEF_RATE = 4;
    localparam int unsigned N_STG    = 3;
    localparam int unsigned CLR_CYC  = 2;

    localparam int MIdle   = 0;
    localparam int MClear  = 1;
    localparam int MActive = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              in_valid;
    logic              cfg_wr;
    logic [RATE_W-1:0] cfg_rate;
    logic              int_clr;
    logic              int_en;
    logic              dec_stb;
    logic              out_valid;
    logic [RATE_W-1:0] rate_cur;
    logic              busy;
    logic              cfg_err;

    int checks   = 0;
    int failures = 0;
    int n_stb    = 0;
    int n_ov     = 0;

    // Reference model state
    int                m_mode;
    int                m_clr_left;
    int                m_acc;
    int                m_strobes;
    logic [RATE_W-1:0] m_rate;
    logic              e_int_clr, e_stb, e_ov, e_err;

    cic_decim_ctrl #(
        .RATE_W  (RATE_W),
        .DEF_RATE(DEF_RATE),
        .N_STG   (N_STG),
        .CLR_CYC (CLR_CYC)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .in_valid_i (in_valid),
        .cfg_wr_i   (cfg_wr),
        .cfg_rate_i (cfg_rate),
        .int_clr_o  (int_clr),
        .int_en_o   (int_en),
        .dec_stb_o  (dec_stb),
        .out_valid_o(out_valid),
        .rate_cur_o (rate_cur),
        .busy_o     (busy),
        .cfg_err_o  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_busy();
        return !((m_mode == MActive) && (m_strobes >= int'(N_STG)));
    endfunction

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        logic illegal, change;
        e_stb = 1'b0;
        e_ov  = 1'b0;
        e_err = 1'b0;
        if (rst) begin
            m_mode = MIdle; m_acc = 0; m_strobes = 0; m_clr_left = 0;
            m_rate = RATE_W'(DEF_RATE);
        end else begin
            illegal = cfg_wr && (cfg_rate < 2);
            change  = cfg_wr && !illegal && (cfg_rate != m_rate);
            e_err   = illegal;
            if (m_mode != MIdle && !en) begin
                m_mode = MIdle; m_acc = 0; m_strobes = 0;
            end else if (m_mode != MIdle && change) begin
                m_mode = MClear; m_clr_left = CLR_CYC; m_acc = 0; m_strobes = 0;
            end else if (m_mode == MIdle) begin
                if (en && !change) begin
                    m_mode = MClear; m_clr_left = CLR_CYC;
                end
            end else if (m_mode == MClear) begin
                m_clr_left--;
                if (m_clr_left == 0) begin
                    m_mode = MActive; m_acc = 0; m_strobes = 0;
                end
            end else if (in_valid) begin
                m_acc++;
                if (m_acc % int'(m_rate) == 0) begin
                    e_stb = 1'b1;
                    e_ov  = (m_strobes >= int'(N_STG));
                    m_strobes++;
                end
            end
            if (change) m_rate = cfg_rate;
        end
        e_int_clr = (m_mode != MActive);
    endtask

    // One clock: check the combinational enable, step model, check registers.
    task automatic tick();
        #1;
        chk("int_en", 32'(int_en), 32'(in_valid && (m_mode == MActive)));
        model_step();
        @(posedge clk);
        #1;
        chk("int_clr", 32'(int_clr), 32'(e_int_clr));
        chk("dec_stb", 32'(dec_stb), 32'(e_stb));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("rate_cur", 32'(rate_cur), 32'(m_rate));
        chk("cfg_err", 32'(cfg_err), 32'(e_err));
        chk("busy", 32'(busy), 32'(m_busy()));
        if (dec_stb) n_stb++;
        if (out_valid) n_ov++;
    endtask

    task automatic drive(input logic r, input logic e, input logic v, input logic w,
                         input logic [RATE_W-1:0] rt);
        rst = r; en = e; in_valid = v; cfg_wr = w; cfg_rate = rt;
        tick();
    endtask

    initial begin
        int stb_at_run;
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; cfg_wr = 1'b0; cfg_rate = '0;
        m_mode = MIdle; m_rate = RATE_W'(DEF_RATE); m_acc = 0; m_strobes = 0;
        m_clr_left = 0;
        @(posedge clk);

        // Reset values
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'd9);
        chk("reset_int_clr", 32'(int_clr), 32'd1);
        chk("reset_rate", 32'(rate_cur), 32'(DEF_RATE));
        chk("reset_busy", 32'(busy), 32'd1);

        // Start with a continuous input stream
        for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
        chk("run_reached", 32'(busy), 32'd0);

        // Sparse input: one sample every third cycle
        stb_at_run = n_stb;
        for (int i = 0; i < 60; i++) drive(1'b0, 1'b1, (i % 3) == 0, 1'b0, '0);
        chk("sparse_strobes", 32'(n_stb - stb_at_run), 32'd5);

        // Rate change to 8 in run, then a random input stream
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd8);
        chk("rate8", 32'(rate_cur), 32'd8);
        for (int i = 0; i < 90; i++) drive(1'b0, 1'b1, $urandom_range(0, 9) < 7, 1'b0, '0);

        // Illegal and same-rate writes
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd8);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, '0);

        // Back to R=4, drop enable mid-settle, re-raise five clocks later
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd4);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, '0);

        // Randomised traffic with occasional writes and enable drops
        for (int i = 0; i < 600; i++) begin
            drive(1'b0,
                  $urandom_range(0, 39) != 0,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 29) == 0,
                  RATE_W'($urandom_range(0, 9)));
        end

        // Settle at R=4 in run, then reset while a write and input are active
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd4);
        for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'd10);
        chk("rst_run_rate", 32'(rate_cur), 32'(DEF_RATE));
        chk("rst_run_clr", 32'(int_clr), 32'd1);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, '0);

        chk("saw_out_valid", 32'(n_ov > 0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cic_decim_ctrl.md
Name: cic_decim_ctrl

Overview:
Sequencing controller for the 3-stage CIC integrator section and its comb section in the decimating CIC filter. It gates the integrator clock enable and clears the integrator and comb registers on start or restart. It generates the decimation strobe that clocks the comb stages at input-rate/R and flags when comb output is valid (pipeline settled). It also owns the runtime decimation-factor register and forces a clean restart on any rate change.

Parameters:
RATE_W, 8, width of decimation factor R
DEF_RATE, 4, R loaded at reset (legal 2..2^RATE_W-1)
N_STG, 3, number of comb stages = decimated strobes discarded after restart
CLR_CYC, 2, cycles int_clr is held in CLEAR (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
en  in  1  run enable; level
in_valid  in  1  input sample strobe at input rate
cfg_wr  in  1  one-cycle write strobe for cfg_rate
cfg_rate  in  RATE_W  new decimation factor R
int_clr  out  1  clear integrator and comb registers (registered)
int_en  out  1  integrator advance enable (combinational: in_valid & state in {SETTLE, RUN})
dec_stb  out  1  comb-section enable, one-cycle pulse per R accepted samples (registered)
out_valid  out  1  comb output valid = dec_stb while in RUN (registered)
rate_cur  out  RATE_W  R currently in effect
busy  out  1  1 when state != RUN
cfg_err  out  1  one-cycle pulse: illegal cfg_rate rejected

Behaviour:
- Reset (rst=1 at clk edge, any state): state=IDLE, phase=0, settle_cnt=0, clr_cnt=0, rate_cur=DEF_RATE, int_clr=1, dec_stb=0, out_valid=0, cfg_err=0, busy=1. rst dominates en, cfg_wr and in_valid.
- States:
  - IDLE: int_clr=1. If en=1, go to CLEAR and set clr_cnt=0.
  - CLEAR: int_clr=1; phase and settle_cnt held at 0; in_valid ignored (int_en=0). clr_cnt increments each cycle. Go to SETTLE when clr_cnt==CLR_CYC-1, so CLEAR lasts exactly CLR_CYC cycles.
  - SETTLE: int_clr=0; decimation runs; out_valid=0.
  - RUN: int_clr=0; decimation runs; out_valid follows dec_stb.
- Decimation, in SETTLE and RUN only:
  - Each in_valid=1 increments phase.
  - If in_valid=1 and phase==rate_cur-1: phase<=0 and dec_stb=1 on the next cycle. Latency is 1 clk after the R-th accepted sample.
  - Cycles without in_valid hold phase.
- Settling: settle_cnt increments on each dec_stb issued in SETTLE. The cycle that issues the N_STG-th dec_stb also moves state to RUN; that strobe has out_valid=0. The first out_valid=1 is the (N_STG+1)-th dec_stb after CLEAR.
- en=0 in any non-IDLE state: next state IDLE. phase and settle_cnt are cleared, and dec_stb/out_valid are 0 from the next cycle.
- Configuration (cfg_wr=1), accepted in any state:
  - cfg_rate<2: rate_cur unchanged, cfg_err=1 next cycle, no state change.
  - cfg_rate==rate_cur: no-op.
  - Otherwise: rate_cur<=cfg_rate next cycle.
    - In IDLE: stay IDLE.
    - In CLEAR, SETTLE or RUN with en=1: restart to CLEAR with clr_cnt=0, phase=0, settle_cnt=0. Any pending dec_stb for that cycle is suppressed.
  - cfg_wr together with en=0: rate applied, state goes to IDLE (en=0 wins over restart).
  - cfg_wr together with in_valid completing a decimation period in RUN: the restart wins and no dec_stb is issued.
- rate_cur never changes except by a legal cfg_wr or by reset.
- phase width is RATE_W. phase never exceeds rate_cur-1. There is no wrap ambiguity because a restart zeroes phase.

Test Plan:
- Reset, then en=1 at cycle 0 with in_valid=1 every cycle (R=4, CLR_CYC=2, N_STG=3) -> int_clr=1 through cycle 2; dec_stb pulses 1 clk after the 4th, 8th, 12th, 16th… accepted samples; out_valid=0 on the first 3 pulses and 1 from the 4th pulse; busy falls with the 3rd pulse.
- in_valid every 3rd cycle, R=4, in RUN -> dec_stb period is exactly 12 clks; int_en mirrors in_valid; phase holds between samples.
- In RUN, cfg_wr with cfg_rate=8 -> rate_cur=8 next cycle; int_clr=1 for 2 cycles; out_valid stays 0 until the 4th dec_stb; then dec_stb every 8 samples.
- cfg_wr with cfg_rate=1 or 0 in RUN -> cfg_err pulses 1 clk; rate_cur stays 4; dec_stb cadence unbroken. cfg_wr with cfg_rate=4 -> no change, no err.
- en dropped mid-SETTLE, then re-raised 5 clks later -> IDLE with int_clr=1; full CLEAR/SETTLE repeated; first out_valid again only on the 4th dec_stb.
- rst=1 for 1 cycle in RUN while in_valid and cfg_wr (rate 10) are active -> next cycle all outputs at reset values, rate_cur=4, state IDLE; write ignored.
